// File: rtl/uch_pkg.sv
// uch_pkg: shared constants and state encoding for the uch sequencer
package uch_pkg;
    localparam int   W_DEF     = 4;
    localparam int   LEN_W_DEF = 8;
    localparam logic SEL_UP    = 1'b1;
    localparam logic SEL_DN    = 1'b0;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_UP    = 3'd2,
        ST_DOWN  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } st_e;
endpackage

// File: rtl/uch_seq_len_cnt.sv
// uch_seq_len_cnt: loadable run-length down-counter with last/zero flags
module uch_seq_len_cnt #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [LEN_W-1:0] ld_val,
    output logic             last,
    output logic             zero
);
    logic [LEN_W-1:0] rem;
    // load wins over decrement; never decrement past zero
    always_ff @(posedge clk) begin
        if (rst) rem <= '0;
        else if (load) rem <= ld_val;
        else if (dec && rem != '0) rem <= rem - 1'b1;
    end
    assign last = rem == LEN_W'(1);
    assign zero = rem == '0;
endmodule

// File: rtl/uch_seq.sv
// uch_seq: sequences a uch counter through clear/up/down and checks its q
module uch_seq
    import uch_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             uch_seq_clk,
    input  logic             uch_seq_rst,
    input  logic             uch_seq_cmd_valid,
    output logic             uch_seq_cmd_ready,
    input  logic [LEN_W-1:0] uch_seq_up_len,
    input  logic [LEN_W-1:0] uch_seq_dn_len,
    input  logic             uch_seq_abort,
    input  logic [W-1:0]     uch_seq_q,
    output logic             uch_seq_cnt_rst,
    output logic             uch_seq_en,
    output logic             uch_seq_sel,
    output logic             uch_seq_busy,
    output logic             uch_seq_done,
    output logic             uch_seq_err
);
    st_e st, nxt;
    logic [W-1:0] exp;
    logic accept, up_last, up_zero, dn_last, dn_zero, cmp;
    assign accept = st == ST_IDLE && uch_seq_cmd_valid;
    assign cmp    = st == ST_UP || st == ST_DOWN || st == ST_CHECK;
    uch_seq_len_cnt #(.LEN_W(LEN_W)) u_up (
        .clk(uch_seq_clk), .rst(uch_seq_rst), .load(accept), .dec(st == ST_UP),
        .ld_val(uch_seq_up_len), .last(up_last), .zero(up_zero)
    );
    uch_seq_len_cnt #(.LEN_W(LEN_W)) u_dn (
        .clk(uch_seq_clk), .rst(uch_seq_rst), .load(accept), .dec(st == ST_DOWN),
        .ld_val(uch_seq_dn_len), .last(dn_last), .zero(dn_zero)
    );
    // state register
    always_ff @(posedge uch_seq_clk) begin
        if (uch_seq_rst) st <= ST_IDLE;
        else st <= nxt;
    end
    // next state; abort overrides everything outside IDLE
    always_comb begin
        nxt = st;
        case (st)
            ST_IDLE:  nxt = uch_seq_cmd_valid ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: nxt = !up_zero ? ST_UP : !dn_zero ? ST_DOWN : ST_CHECK;
            ST_UP:    nxt = !up_last ? ST_UP : dn_zero ? ST_CHECK : ST_DOWN;
            ST_DOWN:  nxt = dn_last ? ST_CHECK : ST_DOWN;
            ST_CHECK: nxt = ST_DONE;
            default:  nxt = ST_IDLE;
        endcase
        if (uch_seq_abort && st != ST_IDLE) nxt = ST_IDLE;
    end
    assign uch_seq_cmd_ready = st == ST_IDLE;
    assign uch_seq_busy      = st != ST_IDLE;
    assign uch_seq_cnt_rst   = st == ST_CLEAR;
    assign uch_seq_en        = st == ST_UP || st == ST_DOWN;
    assign uch_seq_sel       = st == ST_UP ? SEL_UP : SEL_DN;
    assign uch_seq_done      = st == ST_DONE;
    // expected counter value, stepped on the same edge as the counter
    always_ff @(posedge uch_seq_clk) begin
        if (uch_seq_rst || st == ST_CLEAR) exp <= '0;
        else if (st == ST_UP) exp <= exp + 1'b1;
        else if (st == ST_DOWN) exp <= exp - 1'b1;
    end
    // sticky mismatch flag, cleared on accept and held across an abort
    always_ff @(posedge uch_seq_clk) begin
        if (uch_seq_rst || accept) uch_seq_err <= 1'b0;
        else if (cmp && !uch_seq_abort && uch_seq_q != exp) uch_seq_err <= 1'b1;
    end
endmodule

// File: tb/tb_uch_seq.sv
// tb_uch_seq: randomized and directed checks of uch_seq against a schedule model
module tb_uch_seq;
    logic       clk = 1'b0;
    logic       rst, cmd_valid, abort, inj;
    logic [7:0] up_len, dn_len;
    logic       cmd_ready, cnt_rst, en, sel, busy, done, err;
    logic [3:0] cq = 4'd0;
    logic [3:0] q_fed;
    int         cmp_n = 0, mis_n = 0, acc = 0;
    bit         chk_on = 1'b0;

    always #5 clk = ~clk;

    uch_seq dut (
        .uch_seq_clk(clk), .uch_seq_rst(rst), .uch_seq_cmd_valid(cmd_valid),
        .uch_seq_cmd_ready(cmd_ready), .uch_seq_up_len(up_len), .uch_seq_dn_len(dn_len),
        .uch_seq_abort(abort), .uch_seq_q(q_fed), .uch_seq_cnt_rst(cnt_rst),
        .uch_seq_en(en), .uch_seq_sel(sel), .uch_seq_busy(busy),
        .uch_seq_done(done), .uch_seq_err(err)
    );

    // behavioural uch counter: sync clear, enabled up/down, wraps mod 16
    always @(posedge clk) begin
        if (cnt_rst) cq <= 4'd0;
        else if (en) cq <= sel ? cq + 4'd1 : cq - 4'd1;
    end
    // fault injection: corrupt the fed-back q while counting down
    assign q_fed = (inj && en && !sel) ? 4'd7 : cq;

    typedef struct {
        logic       crst, en, sel, done, cmp;
        logic [3:0] eq;
    } ent_t;
    ent_t sched[$];
    logic err_m = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        cmp_n++;
        if (act !== expv) begin
            mis_n++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // model: each accepted command expands into its full per-cycle output schedule
    always @(posedge clk) begin
        ent_t e;
        int u, d;
        if (rst) begin
            sched.delete();
            err_m = 1'b0;
        end else if (sched.size() == 0) begin
            if (cmd_valid) begin
                u = int'(up_len);
                d = int'(dn_len);
                sched.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
                for (int i = 0; i < u; i++) sched.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'(i)});
                for (int j = 0; j < d; j++) sched.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'(u - j)});
                sched.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(u - d)});
                sched.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
                err_m = 1'b0;
            end
        end else begin
            e = sched.pop_front();
            if (abort) sched.delete();
            else if (e.cmp && q_fed != e.eq) err_m = 1'b1;
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            if (sched.size() == 0) begin
                chk("ready", cmd_ready, 1);
                chk("busy", busy, 0);
                chk("en", en, 0);
                chk("sel", sel, 0);
                chk("cnt_rst", cnt_rst, 0);
                chk("done", done, 0);
            end else begin
                chk("ready", cmd_ready, 0);
                chk("busy", busy, 1);
                chk("en", en, sched[0].en);
                chk("sel", sel, sched[0].sel);
                chk("cnt_rst", cnt_rst, sched[0].crst);
                chk("done", done, sched[0].done);
                if (sched[0].cmp) chk("q", cq, sched[0].eq);
            end
            chk("err", err, err_m);
            if (cmd_valid && cmd_ready) acc++;
        end
    end

    task automatic run_cmd(input int u, input int d, input bit hold,
                           output int lat, output logic [3:0] qc);
        int n = 0;
        up_len = 8'(u);
        dn_len = 8'(d);
        cmd_valid = 1'b1;
        qc = 4'hx;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 300) begin
            if (busy && !en && !cnt_rst) qc = cq;
            @(negedge clk);
            lat++;
        end
        chk("done_seen", done, 1);
    endtask

    initial begin
        int lat, ds;
        logic [3:0] qc;
        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; inj = 1'b0;
        up_len = 8'd0; dn_len = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_en", en, 0);
        chk("rst_err", err, 0);
        run_cmd(5, 0, 0, lat, qc);
        chk("t1_lat", lat, 8);
        chk("t1_q", qc, 5);
        chk("t1_err", err, 0);
        @(negedge clk);
        run_cmd(18, 3, 0, lat, qc);
        chk("t2_lat", lat, 24);
        chk("t2_q", qc, 15);
        chk("t2_err", err, 0);
        @(negedge clk);
        run_cmd(0, 0, 0, lat, qc);
        chk("t3_lat", lat, 3);
        chk("t3_q", qc, 0);
        @(negedge clk);
        up_len = 8'd10; dn_len = 8'd10; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_en", en, 0);
        chk("t4_ready", cmd_ready, 1);
        ds = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) ds++;
        end
        chk("t4_nodone", ds, 0);
        run_cmd(3, 1, 0, lat, qc);
        chk("t4_lat", lat, 7);
        @(negedge clk);
        inj = 1'b1;
        run_cmd(4, 2, 0, lat, qc);
        inj = 1'b0;
        chk("t5_err", err, 1);
        @(negedge clk);
        chk("t5_err_idle", err, 1);
        run_cmd(1, 1, 0, lat, qc);
        chk("t5_err_clr", err, 0);
        @(negedge clk);
        acc = 0;
        run_cmd(2, 1, 1, lat, qc);
        run_cmd(2, 1, 1, lat, qc);
        cmd_valid = 1'b0;
        chk("t6_accepts", acc, 2);
        @(negedge clk);
        up_len = 8'd2; dn_len = 8'd0; cmd_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; abort = 1'b0;
        chk("idle_abort_acc", busy, 1);
        repeat (6) @(negedge clk);
        up_len = 8'd6; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err, 0);
        repeat (3000) begin
            @(negedge clk);
            cmd_valid = 1'($urandom_range(0, 1));
            up_len = 8'($urandom_range(0, 20));
            dn_len = 8'($urandom_range(0, 20));
            abort = $urandom_range(0, 49) == 0;
            inj = $urandom_range(0, 29) == 0;
            rst = $urandom_range(0, 399) == 0;
        end
        @(negedge clk);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mis_n);
        $finish;
    end
endmodule
